// File: rtl/sha3_pkg.sv
// sha3_pkg: constants and state encoding shared by the SHA3 read/ingest
// and write-back FSMs.
//   HASH_W      digest width in bits
//   DATA_W      bus beat width in bits
//   BEATS       beats per digest burst
//   BEAT_CNT_W  width of the beat counter
//   LANE_W      Keccak lane width in bits, used by the optional byteswap
//   ST_*        FSM state encoding
//   lane_byteswap() reverses the bytes inside every 64-bit lane of a beat
package sha3_pkg;

    localparam int HASH_W     = 512;
    localparam int DATA_W     = 128;
    localparam int BEATS      = HASH_W / DATA_W;
    localparam int BEAT_CNT_W = $clog2(BEATS);
    localparam int LANE_W     = 64;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_BEATS     = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    // Lane order is kept; only the bytes inside each lane are reversed.
    function automatic logic [DATA_W-1:0] lane_byteswap(input logic [DATA_W-1:0] beat);
        logic [DATA_W-1:0] swapped;
        swapped = '0;
        for (int l = 0; l < DATA_W / LANE_W; l++) begin
            for (int b = 0; b < LANE_W / 8; b++) begin
                swapped[l*LANE_W + (LANE_W/8 - 1 - b)*8 +: 8] = beat[l*LANE_W + b*8 +: 8];
            end
        end
        return swapped;
    endfunction

endpackage

// File: rtl/hash_beat_serializer.sv
// hash_beat_serializer: holds the captured digest and presents it to the
// bus one DATA_W beat at a time, beat 0 = digest bits [DATA_W-1:0].
// Configuration macro: HASH_BYTESWAP_EN -- when defined, every 64-bit lane
// of wr_data is byte-reversed (big-endian digest bytes in memory).
// Ports:
//   clk        in   clock, posedge
//   reset      in   synchronous active-high reset
//   load       in   capture hash_in, rewind to beat 0
//   advance    in   current beat accepted, present the next one
//   hash_in    in   HASH_W digest
//   wr_data    out  DATA_W current beat (registered)
//   last_beat  out  current beat is beat BEATS-1
module hash_beat_serializer
    import sha3_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [HASH_W-1:0] hash_in,
    output logic [DATA_W-1:0] wr_data,
    output logic              last_beat
);

    logic [HASH_W-1:0]     shadow_r;
    logic [BEAT_CNT_W-1:0] beat_cnt_r;
    logic [DATA_W-1:0]     wr_data_r;
    logic [BEAT_CNT_W-1:0] beat_nxt_s;
    logic [DATA_W-1:0]     first_fmt_s;
    logic [DATA_W-1:0]     next_fmt_s;

    // Next beat selection plus optional lane byte reversal for both the
    // load path (beat 0 straight from hash_in) and the advance path.
    always_comb begin
        beat_nxt_s = beat_cnt_r + BEAT_CNT_W'(1);
`ifdef HASH_BYTESWAP_EN
        first_fmt_s = lane_byteswap(hash_in[DATA_W-1:0]);
        next_fmt_s  = lane_byteswap(shadow_r[DATA_W*beat_nxt_s +: DATA_W]);
`else
        first_fmt_s = hash_in[DATA_W-1:0];
        next_fmt_s  = shadow_r[DATA_W*beat_nxt_s +: DATA_W];
`endif
    end

    // Shadow capture, beat counter and registered beat data.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_r   <= '0;
            beat_cnt_r <= '0;
            wr_data_r  <= '0;
        end else if (load) begin
            shadow_r   <= hash_in;
            beat_cnt_r <= '0;
            wr_data_r  <= first_fmt_s;
        end else if (advance) begin
            // After the last beat the counter wraps to 0; the stale data
            // presented then is never marked valid.
            beat_cnt_r <= beat_nxt_s;
            wr_data_r  <= next_fmt_s;
        end else begin
            beat_cnt_r <= beat_cnt_r;
            wr_data_r  <= wr_data_r;
        end
    end

    assign wr_data   = wr_data_r;
    assign last_beat = (beat_cnt_r == BEAT_CNT_W'(BEATS - 1));

endmodule

// File: rtl/hash_writeback_fsm.sv
// hash_writeback_fsm: captures a finished Keccak digest, hands it to the AXI
// burst master as one BEATS-beat write burst, tracks the OCM slot index and
// pulses done when the master reports completion.
// Configuration macro: HASH_BYTESWAP_EN (see hash_beat_serializer).
// Parameter: BASE_INDEX -- write_addr_index value after reset.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   hash_in/valid     digest and its 1-cycle qualifier (accepted in IDLE only)
//   busy              state is not IDLE
//   init_master_txn   1-cycle burst start pulse
//   write_addr_index  OCM slot index of the current burst
//   wr_data/valid     beat to master, wr_data_ready accepts it
//   write_done        master burst complete
//   done              1-cycle completion pulse
//   hash_overrun      sticky: digest dropped while busy or in the done cycle
//   protocol_err      sticky: write_done before all beats were sent
module hash_writeback_fsm
    import sha3_pkg::*;
#(
    parameter logic [31:0] BASE_INDEX = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [HASH_W-1:0] hash_in,
    input  logic              hash_valid,
    output logic              busy,
    output logic              init_master_txn,
    output logic [31:0]       write_addr_index,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_data_valid,
    input  logic              wr_data_ready,
    input  logic              write_done,
    output logic              done,
    output logic              hash_overrun,
    output logic              protocol_err
);

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic        busy_r;
    logic        init_r;
    logic        valid_r;
    logic        done_r;
    logic        overrun_r;
    logic        perr_r;
    logic [31:0] index_r;

    logic        accept_s;
    logic        load_s;
    logic        advance_s;
    logic        init_set_s;
    logic        valid_nxt_s;
    logic        done_set_s;
    logic        index_inc_s;
    logic        overrun_set_s;
    logic        perr_set_s;
    logic        last_beat_s;

    hash_beat_serializer u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (load_s),
        .advance   (advance_s),
        .hash_in   (hash_in),
        .wr_data   (wr_data),
        .last_beat (last_beat_s)
    );

    // Next-state and control decode. Outputs are registered, so init rises
    // in the first BEATS cycle and valid one cycle after that.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        advance_s   = 1'b0;
        init_set_s  = 1'b0;
        valid_nxt_s = valid_r;
        done_set_s  = 1'b0;
        index_inc_s = 1'b0;
        perr_set_s  = 1'b0;
        // The done cycle is already IDLE but a digest arriving then is
        // still treated as an overrun.
        accept_s      = hash_valid && (state_r == ST_IDLE) && !done_r;
        overrun_set_s = hash_valid && !accept_s;
        case (state_r)
            ST_IDLE: begin
                valid_nxt_s = 1'b0;
                if (accept_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (write_done) begin
                    perr_set_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    init_set_s  = 1'b1;
                    state_nxt_s = ST_BEATS;
                end
            end
            ST_BEATS: begin
                if (write_done) begin
                    perr_set_s  = 1'b1;
                    valid_nxt_s = 1'b0;
                    state_nxt_s = ST_IDLE;
                end else if (valid_r && wr_data_ready) begin
                    advance_s = 1'b1;
                    if (last_beat_s) begin
                        valid_nxt_s = 1'b0;
                        state_nxt_s = ST_WAIT_DONE;
                    end else begin
                        valid_nxt_s = 1'b1;
                    end
                end else if (init_r) begin
                    // First BEATS cycle: beat 0 becomes valid next cycle.
                    valid_nxt_s = 1'b1;
                end else begin
                    valid_nxt_s = valid_r;
                end
            end
            ST_WAIT_DONE: begin
                valid_nxt_s = 1'b0;
                if (write_done) begin
                    done_set_s  = 1'b1;
                    index_inc_s = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            default: begin
                valid_nxt_s = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, registered outputs, slot index and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            init_r    <= 1'b0;
            valid_r   <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
            perr_r    <= 1'b0;
            index_r   <= BASE_INDEX;
        end else begin
            state_r   <= state_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
            init_r    <= init_set_s;
            valid_r   <= valid_nxt_s;
            done_r    <= done_set_s;
            overrun_r <= overrun_r | overrun_set_s;
            perr_r    <= perr_r | perr_set_s;
            if (index_inc_s) begin
                index_r <= index_r + 32'd1;
            end else begin
                index_r <= index_r;
            end
        end
    end

    assign busy             = busy_r;
    assign init_master_txn  = init_r;
    assign wr_data_valid    = valid_r;
    assign done             = done_r;
    assign hash_overrun     = overrun_r;
    assign protocol_err     = perr_r;
    assign write_addr_index = index_r;

endmodule

// File: tb/tb_hash_writeback_fsm.sv
// Directed bench for hash_writeback_fsm. Inputs change on the falling edge,
// outputs are checked on the falling edge. A second instance with
// BASE_INDEX = 32'hFFFF_FFFF shares the stimulus to check index wrap/reset.
module tb_hash_writeback_fsm;

    logic         clk = 1'b0;
    logic         reset;
    logic [511:0] hash_in;
    logic         hash_valid;
    logic         wr_data_ready;
    logic         write_done;

    logic         busy, init_master_txn, wr_data_valid, done, hash_overrun, protocol_err;
    logic [31:0]  write_addr_index;
    logic [127:0] wr_data;

    logic         busy2, init2, valid2, done2, ovr2, perr2;
    logic [31:0]  index2;
    logic [127:0] wr_data2;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] A5_BEAT = {16{8'hA5}};
    localparam logic [127:0] H1_B3   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] H2_B0   = 128'h8899_AABB_CCDD_EEFF_0011_2233_4455_6677;
    localparam logic [127:0] H2_B1   = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
    localparam logic [127:0] H2_B2   = 128'h5555_5555_6666_6666_7777_7777_8888_8888;
    localparam logic [127:0] H2_B3   = 128'h9999_9999_AAAA_AAAA_BBBB_BBBB_CCCC_CCCC;
    localparam logic [127:0] H3_B0   = 128'hDEAD_BEEF_0000_0001_DEAD_BEEF_0000_0000;
    localparam logic [127:0] H3_B1   = 128'hDEAD_BEEF_0000_0003_DEAD_BEEF_0000_0002;
    localparam logic [127:0] H3_B2   = 128'hDEAD_BEEF_0000_0005_DEAD_BEEF_0000_0004;
    localparam logic [127:0] H3_B3   = 128'hDEAD_BEEF_0000_0007_DEAD_BEEF_0000_0006;
    localparam logic [511:0] H1 = {H1_B3, A5_BEAT, A5_BEAT, A5_BEAT};
    localparam logic [511:0] H2 = {H2_B3, H2_B2, H2_B1, H2_B0};
    localparam logic [511:0] H3 = {H3_B3, H3_B2, H3_B1, H3_B0};
    localparam logic [511:0] HX = {4{128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0}};

    hash_writeback_fsm dut (
        .clk(clk), .reset(reset), .hash_in(hash_in), .hash_valid(hash_valid),
        .busy(busy), .init_master_txn(init_master_txn), .write_addr_index(write_addr_index),
        .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
        .write_done(write_done), .done(done), .hash_overrun(hash_overrun),
        .protocol_err(protocol_err)
    );

    hash_writeback_fsm #(.BASE_INDEX(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .reset(reset), .hash_in(hash_in), .hash_valid(hash_valid),
        .busy(busy2), .init_master_txn(init2), .write_addr_index(index2),
        .wr_data(wr_data2), .wr_data_valid(valid2), .wr_data_ready(wr_data_ready),
        .write_done(write_done), .done(done2), .hash_overrun(ovr2),
        .protocol_err(perr2)
    );

    always #5 clk = ~clk;

    // Expected on-bus form of a beat: bytes of each 64-bit lane reversed
    // when the byteswap build is selected.
    function automatic logic [127:0] fmt(input logic [127:0] b);
`ifdef HASH_BYTESWAP_EN
        logic [127:0] r;
        for (int lane = 0; lane < 2; lane++) begin
            for (int k = 0; k < 8; k++) begin
                r[lane*64 + (7-k)*8 +: 8] = b[lane*64 + k*8 +: 8];
            end
        end
        return r;
`else
        return b;
`endif
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; hash_in = '0; hash_valid = 1'b0;
        wr_data_ready = 1'b0; write_done = 1'b0;
        tick(); tick();
        // Reset state
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_init", 128'(init_master_txn), 128'd0);
        chk("rst_valid", 128'(wr_data_valid), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_flags", 128'({hash_overrun, protocol_err}), 128'd0);
        chk("rst_index", 128'(write_addr_index), 128'd0);
        chk("rst_index_wrap", 128'(index2), 128'hFFFF_FFFF);
        chk("rst_wr_data", wr_data, 128'd0);
        reset = 1'b0;

        // write_done in IDLE is ignored
        write_done = 1'b1; tick(); write_done = 1'b0;
        chk("idle_done_index", 128'(write_addr_index), 128'd0);
        chk("idle_done_flags", 128'({done, protocol_err, busy}), 128'd0);

        // 1. Nominal burst, ready tied high
        wr_data_ready = 1'b1; hash_in = H1; hash_valid = 1'b1;
        tick(); hash_valid = 1'b0;
        chk("t1_busy", 128'(busy), 128'd1);
        chk("t1_init_early", 128'(init_master_txn), 128'd0);
        tick();
        chk("t1_init", 128'(init_master_txn), 128'd1);
        chk("t1_valid_early", 128'(wr_data_valid), 128'd0);
        tick();
        chk("t1_init_pulse", 128'(init_master_txn), 128'd0);
        chk("t1_b0_valid", 128'(wr_data_valid), 128'd1);
        chk("t1_b0", wr_data, fmt(A5_BEAT));
        tick(); chk("t1_b1", wr_data, fmt(A5_BEAT)); chk("t1_b1_valid", 128'(wr_data_valid), 128'd1);
        tick(); chk("t1_b2", wr_data, fmt(A5_BEAT));
        tick(); chk("t1_b3", wr_data, fmt(H1_B3)); chk("t1_b3_valid", 128'(wr_data_valid), 128'd1);
        tick();
        chk("t1_valid_drop", 128'(wr_data_valid), 128'd0);
        chk("t1_wait_busy", 128'(busy), 128'd1);
        chk("t1_no_done_yet", 128'(done), 128'd0);
        write_done = 1'b1;
        tick(); write_done = 1'b0;
        chk("t1_done", 128'(done), 128'd1);
        chk("t1_index", 128'(write_addr_index), 128'd1);
        chk("t5_index_wrap", 128'(index2), 128'd0);
        chk("t1_idle", 128'(busy), 128'd0);
        tick();
        chk("t1_done_pulse", 128'(done), 128'd0);

        // 2. Backpressure on beat1
        hash_in = H2; hash_valid = 1'b1;
        tick(); hash_valid = 1'b0;
        tick(); chk("t2_init", 128'(init_master_txn), 128'd1);
        tick(); chk("t2_b0", wr_data, fmt(H2_B0));
`ifdef HASH_BYTESWAP_EN
        chk("t6_lane_swap", 128'(wr_data[63:0]), 128'h7766_5544_3322_1100);
`endif
        tick(); chk("t2_b1", wr_data, fmt(H2_B1));
        wr_data_ready = 1'b0;
        tick(); chk("t2_b1_hold1", wr_data, fmt(H2_B1)); chk("t2_hold_valid", 128'(wr_data_valid), 128'd1);
        tick(); chk("t2_b1_hold2", wr_data, fmt(H2_B1));
        tick(); chk("t2_b1_hold3", wr_data, fmt(H2_B1));
        wr_data_ready = 1'b1;
        tick(); chk("t2_b2", wr_data, fmt(H2_B2));
        tick(); chk("t2_b3", wr_data, fmt(H2_B3));
        tick(); chk("t2_valid_drop", 128'(wr_data_valid), 128'd0);
        write_done = 1'b1;
        tick(); write_done = 1'b0;
        chk("t2_done", 128'(done), 128'd1);
        chk("t2_index", 128'(write_addr_index), 128'd2);
        tick();

        // 3. Overrun during BEATS, then in the done cycle
        hash_in = H3; hash_valid = 1'b1;
        tick(); hash_valid = 1'b0;
        tick();
        tick(); chk("t3_b0", wr_data, fmt(H3_B0));
        hash_in = HX; hash_valid = 1'b1;
        tick(); hash_valid = 1'b0;
        chk("t3_overrun", 128'(hash_overrun), 128'd1);
        chk("t3_b1", wr_data, fmt(H3_B1));
        tick(); chk("t3_b2", wr_data, fmt(H3_B2));
        tick(); chk("t3_b3", wr_data, fmt(H3_B3));
        tick(); chk("t3_valid_drop", 128'(wr_data_valid), 128'd0);
        write_done = 1'b1;
        tick(); write_done = 1'b0;
        chk("t3_done", 128'(done), 128'd1);
        chk("t3_index_once", 128'(write_addr_index), 128'd3);
        hash_in = H2; hash_valid = 1'b1;
        tick(); hash_valid = 1'b0;
        chk("t3_donecyc_drop", 128'({busy, init_master_txn}), 128'd0);
        tick();
        chk("t3_donecyc_noinit", 128'({busy, init_master_txn}), 128'd0);
        chk("t3_overrun_sticky", 128'(hash_overrun), 128'd1);

        // 4. Early write_done after beat1
        hash_in = H2; hash_valid = 1'b1;
        tick(); hash_valid = 1'b0;
        tick();
        tick(); chk("t4_b0", wr_data, fmt(H2_B0));
        tick(); chk("t4_b1", wr_data, fmt(H2_B1));
        tick(); chk("t4_b2", wr_data, fmt(H2_B2));
        write_done = 1'b1;
        tick(); write_done = 1'b0;
        chk("t4_perr", 128'(protocol_err), 128'd1);
        chk("t4_idle", 128'({busy, wr_data_valid, done}), 128'd0);
        chk("t4_index", 128'(write_addr_index), 128'd3);
        tick();
        chk("t4_no_done", 128'(done), 128'd0);
        chk("t4_perr_sticky", 128'(protocol_err), 128'd1);

        // 5. Reset mid-BEATS
        hash_in = H1; hash_valid = 1'b1; wr_data_ready = 1'b0;
        tick(); hash_valid = 1'b0;
        tick();
        tick(); chk("t5_valid_before", 128'(wr_data_valid), 128'd1);
        reset = 1'b1;
        tick(); reset = 1'b0;
        chk("t5_rst_valid", 128'(wr_data_valid), 128'd0);
        chk("t5_rst_busy", 128'(busy), 128'd0);
        chk("t5_rst_index", 128'(write_addr_index), 128'd0);
        chk("t5_rst_index_wrap", 128'(index2), 128'hFFFF_FFFF);
        chk("t5_rst_flags", 128'({hash_overrun, protocol_err}), 128'd0);
        chk("t5_rst_shadow", wr_data, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
